// File: rtl/dmem_req_queue.sv
// In-order outstanding-request queue between the LD/ST stage and data memory.
// Requests are enqueued, issued and retired through one circular array by three pointers.
module dmem_req_queue #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32,
  parameter int depth_p      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         core_valid_i,
  input  logic [addr_width_p-1:0]      core_addr_i,
  input  logic [data_width_p-1:0]      core_wdata_i,
  input  logic                         core_wen_i,
  input  logic                         core_byte_i,
  output logic                         core_ready_o,
  output logic                         mem_valid_o,
  output logic [addr_width_p-1:0]      mem_addr_o,
  output logic [data_width_p-1:0]      mem_wdata_o,
  output logic                         mem_wen_o,
  output logic                         mem_byte_o,
  input  logic                         mem_yumi_i,
  input  logic                         mem_rvalid_i,
  input  logic [data_width_p-1:0]      mem_rdata_i,
  output logic                         mem_ryumi_o,
  output logic                         resp_valid_o,
  output logic [data_width_p-1:0]      resp_data_o,
  output logic                         resp_wen_o,
  input  logic                         resp_yumi_i,
  output logic [$clog2(depth_p):0]     occupancy_o
);

  localparam int unsigned PW      = $clog2(depth_p);
  localparam int unsigned CW      = PW + 1;
  localparam int unsigned DEPTH_U = depth_p;
  localparam logic [CW-1:0] DEPTH = CW'(depth_p);

  logic [addr_width_p-1:0] addr_q  [depth_p];
  logic [data_width_p-1:0] wdata_q [depth_p];
  logic                    wen_q   [depth_p];
  logic                    byte_q  [depth_p];

  logic [PW-1:0] wptr, iptr, rptr;
  logic [CW-1:0] count, issued;
  logic          enq, issue, retire;
  logic [data_width_p-1:0] resp_next;

  assign core_ready_o = (count < DEPTH);
  assign enq          = core_valid_i & core_ready_o;

  // Counts disambiguate full vs. empty where the pointers alone would collide.
  assign mem_valid_o  = (count != issued);
  assign mem_addr_o   = addr_q[iptr];
  assign mem_wdata_o  = wdata_q[iptr];
  assign mem_wen_o    = wen_q[iptr];
  assign mem_byte_o   = byte_q[iptr];
  assign issue        = mem_valid_o & mem_yumi_i;

  assign mem_ryumi_o  = mem_rvalid_i & (issued != '0) & (~resp_valid_o | resp_yumi_i);
  assign retire       = mem_ryumi_o;
  assign occupancy_o  = count;

  always_comb begin
    resp_next = '0;
    if (!wen_q[rptr]) begin
      if (byte_q[rptr]) resp_next[7:0] = mem_rdata_i[7:0];
      else              resp_next      = mem_rdata_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH_U; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        wen_q[i]   <= 1'b0;
        byte_q[i]  <= 1'b0;
      end
    end else if (enq) begin
      addr_q[wptr]  <= core_addr_i;
      wdata_q[wptr] <= core_wdata_i;
      wen_q[wptr]   <= core_wen_i;
      byte_q[wptr]  <= core_byte_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr   <= '0;
      iptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      issued <= '0;
    end else begin
      if (enq)    wptr <= wptr + PW'(1);
      if (issue)  iptr <= iptr + PW'(1);
      if (retire) rptr <= rptr + PW'(1);
      count  <= count + CW'(enq) - CW'(retire);
      issued <= issued + CW'(issue) - CW'(retire);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid_o <= 1'b0;
      resp_data_o  <= '0;
      resp_wen_o   <= 1'b0;
    end else if (retire) begin
      resp_valid_o <= 1'b1;
      resp_data_o  <= resp_next;
      resp_wen_o   <= wen_q[rptr];
    end else if (resp_yumi_i) begin
      resp_valid_o <= 1'b0;
    end
  end

endmodule
